audio_path_ctrl: RTL

Parametrised sample-path controller that sits between the I2S receiver and the I2S transmitter in the audio top level. After codec initialisation completes, it buffers incoming ADC samples in a small FIFO and applies a per-sample mode operation: pass, mute, attenuate or gain. Each processed sample is then presented to the DAC writer with a fixed-length enable pulse. Samples that arrive during playback are no longer lost; they are queued, and any overflow is flagged.

---
 rtl/audio_path_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/audio_path_ctrl.sv
// Sample-path controller: queues ADC samples after codec init and replays each one,
// processed by the selected mode, as a fixed-length out_en pulse. AUDIO_PATH_SAT_EN: mode 3 saturates.
module audio_path_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic                       init_done,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_en,
    input  logic [1:0]                 mode,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_en,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_PROC = 2'd2,
        S_PLAY = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] result;
    logic [CW-1:0]     hold_cnt;
    logic              push, pop, push_ok, full, start, finish;

    assign full    = (fifo_level == LW'(DEPTH));
    assign push    = in_en && (state != S_INIT);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            S_INIT: if (init_done) state_next = S_IDLE;
            S_IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = S_PROC;
                end
            end
            S_PROC: begin
                start      = 1'b1;
                state_next = S_PLAY;
            end
            S_PLAY: begin
                if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        result = work;
        case (mode)
            2'd0: result = work;
            2'd1: result = '0;
            2'd2: result = DATA_W'($signed(work) >>> ATTEN_SHIFT);
            2'd3: begin
`ifdef AUDIO_PATH_SAT_EN
                // Doubling overflows exactly when the top two bits differ.
                if (work[DATA_W-1] != work[DATA_W-2])
                    result = work[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                            : {1'b0, {(DATA_W-1){1'b1}}};
                else
                    result = {work[DATA_W-2:0], 1'b0};
`else
                result = {work[DATA_W-2:0], 1'b0};
`endif
            end
            default: result = work;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (push_ok) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            work       <= '0;
            out_data   <= '0;
            out_en     <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                work   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push_ok) fifo_level <= fifo_level - 1'b1;
            if (push && !push_ok) overflow <= 1'b1;

            if (start) begin
                out_data <= result;
                out_en   <= 1'b1;
                hold_cnt <= '0;
            end else if (state == S_PLAY) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (finish) out_en <= 1'b0;
            end
        end
    end

endmodule
